// File: rtl/quant_drain_pkg.sv
// Shared types and defaults for the quantized tile drain stage.
// Row index width, row-beat type and drain FSM states.
package quant_drain_pkg;

    localparam int DEF_ROWS = 32;
    localparam int DEF_COLS = 16;
    localparam int DEF_DW   = 8;

    function automatic int row_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ROW_IDX_W = row_idx_w(DEF_ROWS);

    typedef logic [DEF_COLS*DEF_DW-1:0] row_beat_t;

    typedef enum logic {
        IDLE,
        DRAIN
    } drain_state_e;

endpackage

// File: rtl/quant_tile_drain_if.sv
// Row-beat stream from the tile drain toward writeback/DMA.
// master drives the beat, slave returns out_ready.
interface quant_tile_drain_if
    import quant_drain_pkg::*;
#(
    parameter int COLS       = DEF_COLS,
    parameter int DATA_WIDTH = DEF_DW,
    parameter int ROW_W      = ROW_IDX_W
);
    logic [COLS*DATA_WIDTH-1:0] out_data;
    logic [ROW_W-1:0]           out_row;
    logic                       out_last;
    logic                       out_valid;
    logic                       out_ready;

    modport master (
        output out_data,
        output out_row,
        output out_last,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_row,
        input  out_last,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/quant_drain_buf.sv
// One tile of storage: whole-tile write, one row read by index.
// Contents need no reset; validity is tracked by the owner.
module quant_drain_buf
    import quant_drain_pkg::*;
#(
    parameter int ROWS       = DEF_ROWS,
    parameter int COLS       = DEF_COLS,
    parameter int DATA_WIDTH = DEF_DW,
    parameter int RW         = row_idx_w(ROWS)
) (
    input  logic                                clk,
    input  logic                                we,
    input  logic [ROWS-1:0][COLS*DATA_WIDTH-1:0] wdata,
    input  logic [RW-1:0]                       raddr,
    output logic [COLS*DATA_WIDTH-1:0]          rdata
);
    logic [ROWS-1:0][COLS*DATA_WIDTH-1:0] mem;

    always_ff @(posedge clk) begin
        if (we) mem <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/quant_tile_drain.sv
// Captures a quantized tile and streams it out one row per beat.
// QUANT_DRAIN_DBUF_EN adds a second tile buffer (ping-pong).
module quant_tile_drain
    import quant_drain_pkg::*;
#(
    parameter int ROWS       = DEF_ROWS,
    parameter int COLS       = DEF_COLS,
    parameter int DATA_WIDTH = DEF_DW
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] tile_in,
    input  logic                 tile_valid,
    output logic                 tile_ready,
    quant_tile_drain_if.master   ob,
    output logic                 busy,
    output logic                 drop_err,
    input  logic                 err_clear
);
    localparam int RW = row_idx_w(ROWS);
    localparam int BW = COLS*DATA_WIDTH;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS-1);
`ifdef QUANT_DRAIN_DBUF_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    drain_state_e    state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [NB-1:0]   full_q, full_d, we;
    logic            valid_q, last_q, ready_q, drop_q;
    logic [BW-1:0]   rdata [NB];
    logic [BW-1:0]   rd_row;
    logic            capture, hs, tile_end;

    assign capture  = tile_valid & ready_q;
    assign hs       = valid_q & ob.out_ready;
    assign tile_end = hs & last_q;

`ifdef QUANT_DRAIN_DBUF_EN
    logic rd_sel_q, rd_sel_d, wr_sel;

    // While draining, the read buffer is full, so writes go to the other.
    assign wr_sel = full_q[rd_sel_q] ? ~rd_sel_q : rd_sel_q;
    assign rd_row = rdata[rd_sel_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_sel_q <= 1'b0;
        else          rd_sel_q <= rd_sel_d;
    end
`else
    assign rd_row = rdata[0];
`endif

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        full_d  = full_q;
        we      = '0;
`ifdef QUANT_DRAIN_DBUF_EN
        rd_sel_d = rd_sel_q;
        if (tile_end) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
        end
        if (capture) begin
            we[wr_sel]     = 1'b1;
            full_d[wr_sel] = 1'b1;
        end
`else
        if (tile_end) full_d = '0;
        if (capture) begin
            we[0]     = 1'b1;
            full_d[0] = 1'b1;
        end
`endif
        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = DRAIN;
                    row_d   = '0;
                end
            end
            DRAIN: begin
                if (hs && last_q) begin
                    row_d   = '0;
                    state_d = (|full_d) ? DRAIN : IDLE;
                end else if (hs) begin
                    row_d = row_q + RW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            full_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b1;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            full_q  <= full_d;
            valid_q <= (state_d == DRAIN);
            last_q  <= (state_d == DRAIN) && (row_d == LAST_ROW);
            ready_q <= ~&full_d;
            // A new drop outranks a simultaneous clear.
            if (tile_valid && !ready_q) drop_q <= 1'b1;
            else if (err_clear)         drop_q <= 1'b0;
        end
    end

    for (genvar i = 0; i < NB; i++) begin : g_buf
        quant_drain_buf #(
            .ROWS       (ROWS),
            .COLS       (COLS),
            .DATA_WIDTH (DATA_WIDTH),
            .RW         (RW)
        ) u_buf (
            .clk   (clk),
            .we    (we[i]),
            .wdata (tile_in),
            .raddr (row_q),
            .rdata (rdata[i])
        );
    end

    assign ob.out_data  = valid_q ? rd_row : '0;
    assign ob.out_row   = row_q;
    assign ob.out_last  = last_q;
    assign ob.out_valid = valid_q;
    assign tile_ready   = ready_q;
    assign busy         = valid_q;
    assign drop_err     = drop_q;
endmodule

// File: tb/tb_quant_tile_drain.sv
// Scoreboard bench for quant_tile_drain.
// Stimulus pushes expected beats; a negedge monitor pops and compares.
module tb_quant_tile_drain;
    import quant_drain_pkg::*;

    localparam int R = DEF_ROWS;
    localparam int C = DEF_COLS;
    localparam int W = DEF_DW;
`ifdef QUANT_DRAIN_DBUF_EN
    localparam logic DBUF = 1'b1;
`else
    localparam logic DBUF = 1'b0;
`endif

    typedef logic [R-1:0][C-1:0][W-1:0] tile_t;
    typedef struct packed {
        row_beat_t            d;
        logic [ROW_IDX_W-1:0] r;
        logic                 l;
    } beat_t;

    logic  clk = 1'b0;
    logic  reset_n = 1'b0;
    logic  tile_valid = 1'b0;
    logic  err_clear = 1'b0;
    logic  tile_ready, busy, drop_err;
    tile_t tile_in = '0;

    quant_tile_drain_if ob ();

    quant_tile_drain dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tile_in    (tile_in),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .ob         (ob),
        .busy       (busy),
        .drop_err   (drop_err),
        .err_clear  (err_clear)
    );

    always #5 clk = ~clk;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    rdy_mode = 0;
    int    ph = 0;

    tile_t t_ramp, t_fill, t_junk, t_a, t_b, t_ext;

    // out_ready: always 1, or the repeating 1,0,0,1 pattern
    initial begin
        ob.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) begin
                ob.out_ready = (ph % 4 == 0) || (ph % 4 == 3);
                ph++;
            end else begin
                ob.out_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin : mon
        beat_t act;
        if (reset_n && ob.out_valid) begin
            act = {ob.out_data, ob.out_row, ob.out_last};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL beat_unexpected: got row %0d data %h, want no beat",
                         act.r, act.d);
            end else begin
                if (act !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL beat: got row %0d last %0b data %h, want row %0d last %0b data %h",
                             act.r, act.l, act.d, exp_q[0].r, exp_q[0].l, exp_q[0].d);
                end
                if (ob.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic send_tile(input tile_t t, input bit push);
        int    k;
        beat_t b;
        k = 0;
        while (!tile_ready && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("tile_ready_before_send", tile_ready, 1);
        if (push) begin
            for (int r = 0; r < R; r++) begin
                b.d = t[r];
                b.r = ROW_IDX_W'(r);
                b.l = (r == R-1);
                exp_q.push_back(b);
            end
        end
        tile_in = t;
        tile_valid = 1'b1;
        @(posedge clk);
        #1;
        tile_valid = 1'b0;
    endtask

    task automatic offer(input tile_t t, input logic clr);
        tile_in = t;
        tile_valid = 1'b1;
        err_clear = clr;
        @(posedge clk);
        #1;
        tile_valid = 1'b0;
        err_clear = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (!(tile_ready && !ob.out_valid && exp_q.size() == 0) && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_complete", {tile_ready, ob.out_valid, exp_q.size() == 0}, 3'b101);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_out_valid"}, ob.out_valid, 0);
        chk({nm, "_out_data"}, ob.out_data, 0);
        chk({nm, "_out_row"}, ob.out_row, 0);
        chk({nm, "_out_last"}, ob.out_last, 0);
        chk({nm, "_tile_ready"}, tile_ready, 1);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_drop_err"}, drop_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        beat_t b;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                t_ramp[r][c] = W'(r*16 + c);
                t_fill[r][c] = 8'h3C;
                t_junk[r][c] = 8'hEE;
                t_a[r][c]    = 8'h11;
                t_b[r][c]    = (c % 2 == 0) ? 8'h7F : 8'h80;
                t_ext[r][c]  = ((c + r) % 2 == 0) ? 8'h80 : 8'h7F;
            end
        end

        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // ramp tile, full-rate drain, cycle-exact boundaries
        send_tile(t_ramp, 1);
        chk("t1_tile_ready_drain", tile_ready, DBUF);
        chk("t1_busy", busy, 1);
        chk("t1_row0", ob.out_row, 0);
        chk("t1_row0_data", ob.out_data, 128'h0F0E0D0C0B0A09080706050403020100);
        repeat (30) @(posedge clk);
        #1;
        chk("t1_row30", ob.out_row, 30);
        chk("t1_last_row30", ob.out_last, 0);
        @(posedge clk);
        #1;
        chk("t1_row31", ob.out_row, 31);
        chk("t1_last_row31", ob.out_last, 1);
        chk("t1_row31_data", ob.out_data, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
        chk("t1_ready_row31", tile_ready, DBUF);
        @(posedge clk);
        #1;
        chk("t1_tile_ready_back", tile_ready, 1);
        chk("t1_valid_off", ob.out_valid, 0);
        chk("t1_busy_off", busy, 0);
        chk("t1_all_beats", exp_q.size(), 0);

        // stalled drain
        ph = 0;
        rdy_mode = 1;
        send_tile(t_ramp, 1);
        wait_idle(300);
        rdy_mode = 0;
        @(posedge clk);
        #1;

`ifndef QUANT_DRAIN_DBUF_EN
        // drop during drain, clear, clear colliding with drop
        send_tile(t_fill, 1);
        repeat (4) @(posedge clk);
        #1;
        offer(t_junk, 1'b0);
        chk("drop_set", drop_err, 1);
        chk("drop_cur_tile_active", ob.out_valid, 1);
        wait_idle(100);
        chk("drop_sticky", drop_err, 1);
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
        chk("drop_cleared", drop_err, 0);
        send_tile(t_fill, 1);
        repeat (3) @(posedge clk);
        #1;
        offer(t_junk, 1'b1);
        chk("drop_set_wins", drop_err, 1);
        wait_idle(100);
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
`else
        // ping-pong: second tile 3 cycles later, no bubble
        send_tile(t_a, 1);
        fork
            begin
                for (int i = 0; i < 2*R; i++) begin
                    chk("dbuf_no_gap", ob.out_valid, 1);
                    @(posedge clk);
                    #1;
                end
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                send_tile(t_b, 1);
            end
        join
        wait_idle(20);
        chk("dbuf_no_drop", drop_err, 0);
`endif

        // reset mid-drain
        send_tile(t_ramp, 1);
        repeat (10) @(posedge clk);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk_reset_vals("midreset");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_reset_no_beat", ob.out_valid, 0);
        chk("post_reset_ready", tile_ready, 1);

        // extreme values, hand-written expected rows
        for (int r = 0; r < R; r++) begin
            b.d = (r % 2 == 0) ? 128'h7F807F807F807F807F807F807F807F80
                               : 128'h807F807F807F807F807F807F807F807F;
            b.r = ROW_IDX_W'(r);
            b.l = (r == R-1);
            exp_q.push_back(b);
        end
        send_tile(t_ext, 0);
        wait_idle(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
